i2c_master_cmd_sequencer: RTL and testbench

Write-side companion to the per-node receive FIFOs. It buffers queued I2C commands {rw, sub_addr, data} in an internal command FIFO and drives the I2C master's start_txn/rw/sub_addr/data_in inputs one transaction at a time. It handshakes on the master's busy/done outputs and reports completion and start timeouts. It sits between the system testbench or host logic and the I2C master, in the clk_400 domain.

---
 rtl/i2c_seq_pkg.sv | 12 +
 rtl/i2c_master_cmd_sequencer_if.sv | 20 ++
 rtl/i2c_cmd_fifo.sv | 66 ++++++
 rtl/i2c_master_cmd_sequencer.sv | 127 ++++++++++++
 tb/tb_i2c_master_cmd_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C command sequencer: queued command layout and FSM states.
package i2c_seq_pkg;
  localparam int CMD_W = 16;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} seq_state_t;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
  } i2c_cmd_t;
endpackage

// File: rtl/i2c_master_cmd_sequencer_if.sv
// Command push channel plus the handshake to the I2C master.
interface i2c_master_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       m_start_txn;
  logic       m_rw;
  logic [6:0] m_sub_addr;
  logic [7:0] m_data_in;
  logic       m_busy;
  logic       m_done;

  // slave: the sequencer; master: host logic plus the I2C master model
  modport slave  (input  cmd_valid, cmd_rw, cmd_addr, cmd_data, m_busy, m_done,
                  output cmd_ready, m_start_txn, m_rw, m_sub_addr, m_data_in);
  modport master (output cmd_valid, cmd_rw, cmd_addr, cmd_data, m_busy, m_done,
                  input  cmd_ready, m_start_txn, m_rw, m_sub_addr, m_data_in);
endinterface

// File: rtl/i2c_cmd_fifo.sv
// Command FIFO with synchronous flush; occupancy is registered so full/empty are glitch-free.
module i2c_cmd_fifo
  import i2c_seq_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk_400,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  i2c_cmd_t    din,
  output i2c_cmd_t    dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);
  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  // flush dominates: a same-cycle push is discarded and nothing is popped
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign level   = level_q;
  assign dout    = i2c_cmd_t'(mem_q[rd_ptr_q]);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_400 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_400) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/i2c_master_cmd_sequencer.sv
// Pops queued I2C commands and launches them on the master one at a time,
// with start timeout and an enforced idle gap after each completion.
module i2c_master_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter  int DEPTH         = 8,
  parameter  int START_TIMEOUT = 16,
  parameter  int GAP_CYCLES    = 2,
  localparam int LW            = $clog2(DEPTH) + 1
) (
  input  logic                        clk_400,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        flush,
  i2c_master_cmd_sequencer_if.slave   bus,
  output logic                        txn_done,
  output logic                        err_timeout,
  output logic [15:0]                 txn_count,
  output logic [LW-1:0]               fifo_level,
  output logic                        seq_busy
);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  seq_state_t     state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [GW-1:0]  gap_q, gap_d;
  i2c_cmd_t       cmd_q, cmd_d, head, din;
  logic           start_q, start_d, done_q, done_d, tmo_q, tmo_d;
  logic [15:0]    count_q, count_d;
  logic           pop, full, empty, complete;

  assign din = '{rw: bus.cmd_rw, addr: bus.cmd_addr, data: bus.cmd_data};

  i2c_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_400 (clk_400),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (bus.cmd_valid),
    .pop     (pop),
    .din     (din),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    gap_d    = gap_q;
    cmd_d    = cmd_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    tmo_d    = 1'b0;
    count_d  = count_q;
    pop      = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        // a flushed head must not be launched
        if (enable && !empty && !bus.m_busy && !flush) begin
          pop     = 1'b1;
          cmd_d   = head;
          timer_d = '0;
          start_d = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (bus.m_done)                              complete = 1'b1;
        else if (bus.m_busy)                         state_d  = WAIT_DONE;
        else if (timer_q == TW'(START_TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
          start_d = 1'b1;
        end
      end
      WAIT_DONE: if (bus.m_done) complete = 1'b1;
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (complete) begin
      done_d  = 1'b1;
      count_d = count_q + 1'b1;
      gap_d   = GW'(GAP_CYCLES - 1);
      state_d = GAP;
    end
  end

  always_ff @(posedge clk_400 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      gap_q   <= '0;
      cmd_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      cmd_q   <= cmd_d;
      start_q <= start_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      count_q <= count_d;
    end
  end

  assign bus.cmd_ready   = !full;
  assign bus.m_start_txn = start_q;
  assign bus.m_rw        = cmd_q.rw;
  assign bus.m_sub_addr  = cmd_q.addr;
  assign bus.m_data_in   = cmd_q.data;
  assign txn_done        = done_q;
  assign err_timeout     = tmo_q;
  assign txn_count       = count_q;
  assign seq_busy        = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_i2c_master_cmd_sequencer.sv
// Directed bench: I2C master model (busy 3 cycles after start, done 40 later) plus launch monitor.
module tb_i2c_master_cmd_sequencer;
  import i2c_seq_pkg::*;

  logic        clk_400 = 1'b0;
  logic        rst_n   = 1'b0;
  logic        enable  = 1'b0;
  logic        flush   = 1'b0;
  logic        txn_done, err_timeout, seq_busy;
  logic [15:0] txn_count;
  logic [3:0]  fifo_level;

  i2c_master_cmd_sequencer_if bus();

  i2c_master_cmd_sequencer #(.DEPTH(8), .START_TIMEOUT(16), .GAP_CYCLES(2)) dut (
    .clk_400     (clk_400),
    .rst_n       (rst_n),
    .enable      (enable),
    .flush       (flush),
    .bus         (bus.slave),
    .txn_done    (txn_done),
    .err_timeout (err_timeout),
    .txn_count   (txn_count),
    .fifo_level  (fifo_level),
    .seq_busy    (seq_busy)
  );

  always #5 clk_400 = ~clk_400;

  int   n_vec = 0, n_err = 0, cyc = 0, phase = 0, mcnt = 0, run = 0;
  int   n_done = 0, n_tmo = 0, n_both = 0, push_cyc = 0;
  bit   no_busy = 1'b0;
  logic prev_start = 1'b0;
  int   log_addr[$], log_data[$], log_rw[$], log_cyc[$], log_lvl[$], log_run[$], done_cyc[$];

  initial forever begin
    @(posedge clk_400);
    cyc = cyc + 1;
  end

  // I2C master model
  initial begin
    bus.m_busy = 1'b0;
    bus.m_done = 1'b0;
    forever begin
      @(negedge clk_400);
      if (!rst_n) begin
        phase = 0; mcnt = 0; bus.m_busy = 1'b0; bus.m_done = 1'b0;
      end else begin
        case (phase)
          0: if (bus.m_start_txn && !no_busy) begin
               mcnt++;
               if (mcnt == 3) begin bus.m_busy = 1'b1; phase = 1; mcnt = 0; end
             end
          1: begin
               mcnt++;
               if (mcnt == 40) begin bus.m_busy = 1'b0; bus.m_done = 1'b1; phase = 2; end
             end
          default: begin bus.m_done = 1'b0; phase = 0; mcnt = 0; end
        endcase
      end
    end
  end

  // launch / completion monitor
  initial forever begin
    @(negedge clk_400);
    if (!rst_n) begin
      prev_start = 1'b0;
      run = 0;
    end else begin
      if (bus.m_start_txn && !prev_start) begin
        log_addr.push_back(int'(bus.m_sub_addr));
        log_data.push_back(int'(bus.m_data_in));
        log_rw.push_back(int'(bus.m_rw));
        log_cyc.push_back(cyc);
        log_lvl.push_back(int'(fifo_level));
        run = 1;
      end else if (bus.m_start_txn) run++;
      if (!bus.m_start_txn && prev_start) log_run.push_back(run);
      if (txn_done) begin n_done++; done_cyc.push_back(cyc); end
      if (err_timeout) n_tmo++;
      if (txn_done && err_timeout) n_both++;
      prev_start = bus.m_start_txn;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic rw, input logic [6:0] addr, input logic [7:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = rw;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    @(negedge clk_400);
    bus.cmd_valid = 1'b0;
    push_cyc      = cyc;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_400);
      if (!seq_busy) begin ok = 1'b1; break; end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk_400);
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; no_busy = 1'b0;
    bus.cmd_valid = 1'b0;
    log_addr.delete(); log_data.delete(); log_rw.delete(); log_cyc.delete();
    log_lvl.delete(); log_run.delete(); done_cyc.delete();
    n_done = 0; n_tmo = 0;
    repeat (2) @(negedge clk_400);
    rst_n = 1'b1;
    @(negedge clk_400);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_addr = '0; bus.cmd_data = '0;

    // reset state
    repeat (2) @(negedge clk_400);
    chk("rst_ready",  32'(bus.cmd_ready),   32'd1);
    chk("rst_start",  32'(bus.m_start_txn), 32'd0);
    chk("rst_maddr",  32'(bus.m_sub_addr),  32'd0);
    chk("rst_mdata",  32'(bus.m_data_in),   32'd0);
    chk("rst_level",  32'(fifo_level),      32'd0);
    chk("rst_count",  32'(txn_count),       32'd0);
    chk("rst_busy",   32'(seq_busy),        32'd0);
    chk("rst_pulses", 32'({txn_done, err_timeout}), 32'd0);
    do_reset();

    // single write
    enable = 1'b1;
    push(1'b0, 7'h01, 8'hA5);
    wait_idle("sw_idle", 200);
    chk("sw_launches", log_addr.size(), 1);
    chk("sw_addr",  log_addr[0], 32'h01);
    chk("sw_data",  log_data[0], 32'hA5);
    chk("sw_rw",    log_rw[0], 0);
    chk("sw_lat",   log_cyc[0] - push_cyc, 1);
    chk("sw_run",   log_run[0], 3);
    chk("sw_ndone", n_done, 1);
    chk("sw_count", 32'(txn_count), 32'd1);
    chk("sw_hold",  32'(bus.m_data_in), 32'hA5);

    // back-to-back
    do_reset();
    push(1'b0, 7'h01, 8'h11);
    push(1'b0, 7'h03, 8'h22);
    push(1'b0, 7'h01, 8'h33);
    chk("bb_lvl3", 32'(fifo_level), 32'd3);
    enable = 1'b1;
    wait_idle("bb_idle", 400);
    chk("bb_launches", log_addr.size(), 3);
    chk("bb_order", {log_addr[0][7:0], log_addr[1][7:0], log_addr[2][7:0]}, 32'h010301);
    chk("bb_data",  {log_data[0][7:0], log_data[1][7:0], log_data[2][7:0]}, 32'h112233);
    chk("bb_levels", {log_lvl[0][7:0], log_lvl[1][7:0], log_lvl[2][7:0]}, 32'h020100);
    chk("bb_gap1",  log_cyc[1] - done_cyc[0], 3);
    chk("bb_gap2",  log_cyc[2] - done_cyc[1], 3);
    chk("bb_count", 32'(txn_count), 32'd3);

    // full FIFO
    do_reset();
    for (int i = 1; i <= 8; i++) push(1'b0, 7'h10, 8'(i));
    chk("full_ready", 32'(bus.cmd_ready), 32'd0);
    push(1'b0, 7'h10, 8'h09);
    chk("full_lvl", 32'(fifo_level), 32'd8);
    enable = 1'b1;
    wait_idle("full_idle", 800);
    chk("full_launches", log_addr.size(), 8);
    chk("full_first", log_data[0], 1);
    chk("full_last",  log_data[7], 8);
    chk("full_count", 32'(txn_count), 32'd8);

    // start timeout
    begin
      bit seen = 1'b0;
      do_reset();
      no_busy = 1'b1;
      enable  = 1'b1;
      push(1'b0, 7'h05, 8'h55);
      push(1'b0, 7'h06, 8'h66);
      for (int i = 0; i < 100; i++) begin
        @(negedge clk_400);
        if (err_timeout) begin no_busy = 1'b0; seen = 1'b1; break; end
      end
      chk("to_seen",  32'(seen), 32'd1);
      chk("to_cnt0",  32'(txn_count), 32'd0);
      wait_idle("to_idle", 200);
      chk("to_run",   log_run[0], 16);
      chk("to_pulse", n_tmo, 1);
      chk("to_next",  log_addr[1], 32'h06);
      chk("to_count", 32'(txn_count), 32'd1);
    end

    // flush during WAIT_DONE
    begin
      bit fell = 1'b0;
      do_reset();
      enable = 1'b1;
      for (int i = 0; i < 4; i++) push(1'b0, 7'(8'h0A + i), 8'(8'hC0 + i));
      for (int i = 0; i < 50; i++) begin
        if (log_run.size() != 0) begin fell = 1'b1; break; end
        @(negedge clk_400);
      end
      chk("fl_fell", 32'(fell), 32'd1);
      chk("fl_lvl_pre", 32'(fifo_level), 32'd3);
      flush = 1'b1;
      @(negedge clk_400);
      flush = 1'b0;
      chk("fl_lvl0", 32'(fifo_level), 32'd0);
      wait_idle("fl_idle", 200);
      repeat (10) @(negedge clk_400);
      chk("fl_launches", log_addr.size(), 1);
      chk("fl_count", 32'(txn_count), 32'd1);
      chk("fl_hold",  32'(bus.m_data_in), 32'hC0);
    end

    // asynchronous reset in LAUNCH
    push(1'b0, 7'h21, 8'h77);
    push(1'b0, 7'h22, 8'h78);
    chk("rm_start_pre", 32'(bus.m_start_txn), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_start", 32'(bus.m_start_txn), 32'd0);
    chk("rm_level", 32'(fifo_level), 32'd0);
    chk("rm_count", 32'(txn_count), 32'd0);
    @(negedge clk_400);
    rst_n = 1'b1;
    @(negedge clk_400);
    chk("rm_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rm_busy",  32'(seq_busy), 32'd0);
    chk("never_both", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
